// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, immediate select, load-use hazard detect.
// Latency: one cycle from ID inputs to the EX register; forwarding and operand mux are combinational after it.
// Backpressure: stall_in holds the register; hazard_stall asks decode to hold its slot while a bubble is loaded.
// Build option: define ALU_FWD_EN for MEM/WB forwarding; without it, RAW dependences on EX/MEM stall instead.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_alu_ctr,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [2:0]        alu_ctr,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [2:0]        alu_ctr;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_slot_t;

  ex_slot_t          ex_d, ex_q;
  logic              load_use;
  logic              raw_dep;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // A producer index matches only when nonzero: register 0 is hardwired and never a dependence.
  function automatic logic idx_hit(input logic [REG_AW-1:0] prod, input logic [REG_AW-1:0] idx);
    return (prod != '0) && (prod == idx);
  endfunction

  // Hazard detect: load-use always; without forwarding, any pending EX/MEM write to a source too.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (idx_hit(ex_q.rd, id_rs) || idx_hit(ex_q.rd, id_rt));
    raw_dep  = 1'b0;
`ifndef ALU_FWD_EN
    raw_dep  = (ex_q.valid && ex_q.reg_write && (idx_hit(ex_q.rd, id_rs) || idx_hit(ex_q.rd, id_rt)))
            || (mem_reg_write && (idx_hit(mem_rd, id_rs) || idx_hit(mem_rd, id_rt)));
`endif
    // A flushed slot is dead anyway; during reset every output must read 0.
    hazard_stall = rst_n && id_valid && !flush_in && (load_use || raw_dep);
  end

  // Next EX contents: flush beats stall beats hazard bubble beats a normal load.
  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (hazard_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.use_imm    = id_use_imm;
      ex_d.alu_ctr    = id_alu_ctr;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  // ID/EX register; reset discards whatever was held, including a stalled instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Operand forwarding: the younger MEM result wins over WB.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    rt_fwd = ex_q.rt_data;
`ifdef ALU_FWD_EN
    if (mem_reg_write && idx_hit(mem_rd, ex_q.rs))     rs_fwd = mem_result;
    else if (wb_reg_write && idx_hit(wb_rd, ex_q.rs))  rs_fwd = wb_result;
    if (mem_reg_write && idx_hit(mem_rd, ex_q.rt))     rt_fwd = mem_result;
    else if (wb_reg_write && idx_hit(wb_rd, ex_q.rt))  rt_fwd = wb_result;
`endif
  end

`ifndef ALU_FWD_EN
  // Without forwarding these inputs only matter to the hazard logic, or not at all.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{wb_reg_write, wb_rd, wb_result, mem_result, ex_q.rs, ex_q.rt};
`endif

  // EX outputs; an invalid slot presents a zero operation so nothing stale leaks downstream.
  always_comb begin
    ex_valid      = ex_q.valid;
    alu_src1      = ex_q.valid ? rs_fwd : '0;
    alu_src2      = ex_q.valid ? (ex_q.use_imm ? ex_q.imm : rt_fwd) : '0;
    alu_ctr       = ex_q.valid ? ex_q.alu_ctr : 3'b000;
    ex_store_data = ex_q.valid ? rt_fwd : '0;
    ex_rd         = ex_q.rd;
    ex_reg_write  = ex_q.valid && ex_q.reg_write;
    ex_mem_read   = ex_q.valid && ex_q.mem_read;
    ex_mem_write  = ex_q.valid && ex_q.mem_write;
    ex_mem_to_reg = ex_q.valid && ex_q.mem_to_reg;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios plus randomized traffic against a slot-level model.
// The model tracks which instruction the EX slot should hold and derives outputs from the stage rules.
// Expectations follow the ALU_FWD_EN setting of the build.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_ctr;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        stall_in, flush_in;
  logic        hazard_stall, ex_valid;
  logic [31:0] alu_src1, alu_src2, ex_store_data;
  logic [2:0]  alu_ctr;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctr(id_alu_ctr),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_in(stall_in), .flush_in(flush_in),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The instruction the EX slot should be holding.
  typedef struct packed {
    logic        v;
    logic [31:0] rs_data, rt_data, imm;
    logic        use_imm;
    logic [2:0]  ctr;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, mtr;
  } slot_t;

  slot_t m;

  function automatic slot_t id_slot();
    slot_t s;
    s = {id_valid, id_rs_data, id_rt_data, id_imm, id_use_imm, id_alu_ctr,
         id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg};
    return s;
  endfunction

  function automatic bit dep(input logic [4:0] prod, input logic [4:0] a, input logic [4:0] b);
    return (prod != 0) && ((prod == a) || (prod == b));
  endfunction

  // Should decode be told to hold, given the EX slot and the current inputs?
  function automatic bit exp_hazard();
    bit h;
    if (!rst_n || !id_valid || flush_in) return 1'b0;
    h = m.v && m.mr && dep(m.rd, id_rs, id_rt);
`ifndef ALU_FWD_EN
    if (m.v && m.rw && dep(m.rd, id_rs, id_rt)) h = 1'b1;
    if (mem_reg_write && dep(mem_rd, id_rs, id_rt)) h = 1'b1;
`endif
    return h;
  endfunction

  // Value an operand with register index idx should see this cycle.
  function automatic logic [31:0] exp_fwd(input logic [4:0] idx, input logic [31:0] raw);
`ifdef ALU_FWD_EN
    if (idx == 0) return raw;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_result;
`endif
    return raw;
  endfunction

  function automatic logic [3:0] exp_ctl();
    return m.v ? {m.rw, m.mr, m.mw, m.mtr} : 4'b0000;
  endfunction

  // One clock edge; the model takes the slot the stage rules dictate.
  task automatic tick();
    bit hz;
    hz = exp_hazard();
    @(posedge clk);
    if (!rst_n || flush_in || (!stall_in && hz)) m = '0;
    else if (!stall_in) m = id_slot();
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0;
    id_alu_ctr = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    stall_in = 0; flush_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    m = '0;
    id_valid = 1; id_rs = 3; id_rs_data = 32'hDEAD; id_alu_ctr = 3'b111; id_reg_write = 1;
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'h77;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
    checks++; if ({alu_src1, alu_src2, ex_store_data} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h expected 0", alu_src1, alu_src2, ex_store_data); end
    checks++; if ({alu_ctr, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 12'h0) begin errors++; $display("FAIL reset_ctl: got %h %h %b%b%b%b expected 0", alu_ctr, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_basic_latch();
    clear_inputs();
    id_valid = 1; id_rs_data = 32'h5; id_rt_data = 32'h3; id_alu_ctr = 3'b101;
    id_rs = 1; id_rt = 2; id_rd = 3; id_reg_write = 1;
    tick();
    checks++; if (alu_src1 !== 32'h5) begin errors++; $display("FAIL latch_src1: got %h expected 5", alu_src1); end
    checks++; if (alu_src2 !== 32'h3) begin errors++; $display("FAIL latch_src2: got %h expected 3", alu_src2); end
    checks++; if (alu_ctr !== 3'b101) begin errors++; $display("FAIL latch_ctr: got %b expected 101", alu_ctr); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL latch_valid: got %b expected 1", ex_valid); end
    checks++; if ({ex_rd, ex_reg_write} !== {5'd3, 1'b1}) begin errors++; $display("FAIL latch_rd: got %0d/%b expected 3/1", ex_rd, ex_reg_write); end
  endtask

  task automatic test_immediate();
    clear_inputs();
    id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFF_FFFC; id_rt_data = 32'h7; id_rs_data = 32'h1;
    id_rs = 1; id_rt = 2; id_rd = 4; id_alu_ctr = 3'b010;
    tick();
    checks++; if (alu_src2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_src2: got %h expected fffffffc", alu_src2); end
    checks++; if (ex_store_data !== 32'h7) begin errors++; $display("FAIL imm_store: got %h expected 7", ex_store_data); end
  endtask

  task automatic test_forwarding();
    logic [31:0] e;
    clear_inputs();
    id_valid = 1; id_rs = 4; id_rt = 0; id_rs_data = 32'h11; id_rt_data = 0; id_rd = 5; id_alu_ctr = 3'b001;
    tick();
    mem_reg_write = 1; mem_rd = 4; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'hBB;
    #1;
`ifdef ALU_FWD_EN
    e = 32'hAA;
`else
    e = 32'h11;
`endif
    checks++; if (alu_src1 !== e) begin errors++; $display("FAIL fwd_mem_over_wb: got %h expected %h", alu_src1, e); end
    checks++; if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL fwd_mem_hazard: got %b expected %b", hazard_stall, exp_hazard()); end
    mem_reg_write = 0;
    #1;
`ifdef ALU_FWD_EN
    e = 32'hBB;
`else
    e = 32'h11;
`endif
    checks++; if (alu_src1 !== e) begin errors++; $display("FAIL fwd_wb: got %h expected %h", alu_src1, e); end
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h1234;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'h5555;
    #1;
    checks++; if (alu_src2 !== 32'h0) begin errors++; $display("FAIL fwd_reg0_src2: got %h expected 0", alu_src2); end
    checks++; if (ex_store_data !== 32'h0) begin errors++; $display("FAIL fwd_reg0_store: got %h expected 0", ex_store_data); end
    checks++; if (alu_src1 !== 32'h11) begin errors++; $display("FAIL fwd_nomatch_src1: got %h expected 11", alu_src1); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rd = 9; id_rs = 1; id_rt = 2;
    tick();
    id_rs = 9; id_rt = 3; id_rd = 10; id_mem_read = 0; id_mem_to_reg = 0; id_alu_ctr = 3'b110; id_rs_data = 32'h99;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b expected 1", hazard_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble_valid: got %b expected 0", ex_valid); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b0) begin errors++; $display("FAIL loaduse_bubble_ctl: got %b%b%b%b expected 0000", ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    checks++; if ({alu_ctr, alu_src1, alu_src2} !== 67'h0) begin errors++; $display("FAIL loaduse_bubble_alu: got %b %h %h expected 0", alu_ctr, alu_src1, alu_src2); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %b expected 0", hazard_stall); end
    id_rs = 1; id_rt = 2; id_rd = 9; id_mem_read = 1; id_reg_write = 1;
    tick();
    id_rs = 9; id_rd = 10; id_mem_read = 0; flush_in = 1;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL flush_hazard: got %b expected 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b0) begin errors++; $display("FAIL flush_bubble: got %b %b%b%b%b expected 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    clear_inputs();
  endtask

  task automatic test_raw_stall();
    bit e;
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rd = 6; id_rs = 1; id_rt = 2;
    tick();
    id_rs = 0; id_rt = 6; id_rd = 7;
    #1;
`ifdef ALU_FWD_EN
    e = 1'b0;
`else
    e = 1'b1;
`endif
    checks++; if (hazard_stall !== e) begin errors++; $display("FAIL raw_ex_stall: got %b expected %b", hazard_stall, e); end
    id_rt = 0; id_rs = 12; mem_reg_write = 1; mem_rd = 12;
    #1;
    checks++; if (hazard_stall !== e) begin errors++; $display("FAIL raw_mem_stall: got %b expected %b", hazard_stall, e); end
    mem_reg_write = 0; wb_reg_write = 1; wb_rd = 12;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_wb_nostall: got %b expected 0", hazard_stall); end
    clear_inputs();
  endtask

  task automatic test_stall_reset();
    clear_inputs();
    id_valid = 1; id_rs_data = 32'h1234; id_rt_data = 32'h5678; id_alu_ctr = 3'b010;
    id_rs = 1; id_rt = 2; id_rd = 7; id_reg_write = 1; id_mem_write = 1;
    tick();
    stall_in = 1;
    id_rs_data = 32'hFFFF; id_rt_data = 32'hEEEE; id_alu_ctr = 3'b110; id_rs = 3; id_rt = 4; id_rd = 8;
    id_mem_write = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({alu_src1, alu_src2} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL stall_hold_ops[%0d]: got %h %h expected 1234 5678", i, alu_src1, alu_src2); end
      checks++; if ({ex_valid, alu_ctr, ex_rd} !== {1'b1, 3'b010, 5'd7}) begin errors++; $display("FAIL stall_hold_ctr[%0d]: got %b %b %0d expected 1 010 7", i, ex_valid, alu_ctr, ex_rd); end
      checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b1010) begin errors++; $display("FAIL stall_hold_ctl[%0d]: got %b%b%b%b expected 1010", i, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    end
    #2;
    rst_n = 0;
    m = '0;
    #1;
    checks++; if ({ex_valid, hazard_stall, alu_ctr, ex_rd} !== 10'b0) begin errors++; $display("FAIL async_reset_ctl: got %b %b %b %0d expected 0", ex_valid, hazard_stall, alu_ctr, ex_rd); end
    checks++; if ({alu_src1, alu_src2, ex_store_data} !== 96'h0) begin errors++; $display("FAIL async_reset_data: got %h %h %h expected 0", alu_src1, alu_src2, ex_store_data); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b0) begin errors++; $display("FAIL async_reset_flags: got %b%b%b%b expected 0", ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    @(negedge clk);
    rst_n = 1;
    stall_in = 0;
    tick();
    checks++; if ({ex_valid, alu_ctr, ex_rd} !== {1'b1, 3'b110, 5'd8}) begin errors++; $display("FAIL post_reset_load: got %b %b %0d expected 1 110 8", ex_valid, alu_ctr, ex_rd); end
    checks++; if (alu_src1 !== 32'hFFFF) begin errors++; $display("FAIL post_reset_src1: got %h expected ffff", alu_src1); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, es;
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs_data    = $urandom;
      id_rt_data    = $urandom;
      id_imm        = $urandom;
      id_use_imm    = $urandom_range(0, 1);
      id_alu_ctr    = $urandom_range(0, 7);
      id_rs         = $urandom_range(0, 3);
      id_rt         = $urandom_range(0, 3);
      id_rd         = $urandom_range(0, 3);
      id_reg_write  = $urandom_range(0, 1);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      id_mem_write  = ($urandom_range(0, 3) == 0);
      id_mem_to_reg = $urandom_range(0, 1);
      mem_reg_write = $urandom_range(0, 1);
      mem_rd        = $urandom_range(0, 3);
      mem_result    = $urandom;
      wb_reg_write  = $urandom_range(0, 1);
      wb_rd         = $urandom_range(0, 3);
      wb_result     = $urandom;
      stall_in      = ($urandom_range(0, 5) == 0);
      flush_in      = ($urandom_range(0, 9) == 0);
      #1;
      if (id_valid) begin
        checks++; if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL rnd_hazard[%0d]: got %b expected %b", i, hazard_stall, exp_hazard()); end
      end
      checks++; if (ex_valid !== m.v) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, ex_valid, m.v); end
      checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b%b%b%b expected %b", i, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, exp_ctl()); end
      if (m.v) begin
        e1 = exp_fwd(m.rs, m.rs_data);
        es = exp_fwd(m.rt, m.rt_data);
        e2 = m.use_imm ? m.imm : es;
        checks++; if (alu_src1 !== e1) begin errors++; $display("FAIL rnd_src1[%0d]: got %h expected %h", i, alu_src1, e1); end
        checks++; if (alu_src2 !== e2) begin errors++; $display("FAIL rnd_src2[%0d]: got %h expected %h", i, alu_src2, e2); end
        checks++; if (ex_store_data !== es) begin errors++; $display("FAIL rnd_store[%0d]: got %h expected %h", i, ex_store_data, es); end
        checks++; if ({alu_ctr, ex_rd} !== {m.ctr, m.rd}) begin errors++; $display("FAIL rnd_ctr_rd[%0d]: got %b %0d expected %b %0d", i, alu_ctr, ex_rd, m.ctr, m.rd); end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_latch();
    test_immediate();
    test_forwarding();
    test_load_use();
    test_raw_stall();
    test_stall_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the 32-bit ALU.
- Latches decoded operands and controls each cycle, then applies MEM/WB forwarding and the immediate select.
- Drives the ALU operand and control inputs (alu_src1, alu_src2, alu_ctr).
- Detects load-use hazards, requests a decode stall and inserts a bubble.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data  in  DATA_W  register-file read port A
- id_rt_data  in  DATA_W  register-file read port B
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_use_imm  in  1  1: ALU operand 2 takes the immediate
- id_alu_ctr  in  3  ALU op select
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls
- mem_reg_write  in  1  EX/MEM stage writes a register
- mem_rd  in  REG_AW  EX/MEM destination
- mem_result  in  DATA_W  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB stage writes a register
- wb_rd  in  REG_AW  MEM/WB destination
- wb_result  in  DATA_W  MEM/WB writeback value
- stall_in  in  1  downstream hold
- flush_in  in  1  kill the instruction being latched (branch/jump)
- hazard_stall  out  1  decode must hold its slot this cycle
- ex_valid  out  1  EX slot holds a real instruction
- alu_src1, alu_src2  out  DATA_W  ALU operands
- alu_ctr  out  3  ALU op select
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd  out  REG_AW  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls, forced 0 when ex_valid=0

Behaviour:
- Reset: all registers clear asynchronously on rst_n low. All outputs read 0 while in reset.
- Latency: one cycle, ID inputs to registered EX outputs. Forwarding and the operand mux are combinational after the register.
- Register update at each rising edge, in priority order:
  - flush_in=1: load bubble (valid=0, all controls 0, data 0).
  - else stall_in=1: hold all contents.
  - else hazard_stall=1: load bubble.
  - else: load the ID inputs, with valid=id_valid.
- hazard_stall is combinational. It is 1 when all of the following hold:
  - ex_valid, ex_mem_read and id_valid are 1;
  - ex_rd is nonzero;
  - ex_rd equals id_rs, or ex_rd equals id_rt.
- hazard_stall is 0 when flush_in=1.
- Forwarding for each of the registered rs and rt:
  - Take mem_result if mem_reg_write=1, mem_rd is nonzero and mem_rd equals the index.
  - Otherwise take wb_result if wb_reg_write=1, wb_rd is nonzero and wb_rd equals the index.
  - Otherwise take the registered read data.
  - MEM has priority over WB. Index 0 is never forwarded.
- Operand mapping:
  - alu_src1 = forwarded rs.
  - alu_src2 = registered imm when use_imm=1, else forwarded rt.
  - ex_store_data = forwarded rt regardless of use_imm.
- Bubble ALU inputs: alu_ctr=0 and operands 0, so the downstream zero flag reads 1. Consumers must qualify it with ex_valid.
- Reset asserted mid-stall discards the held instruction. After reset release, the first edge loads ID normally.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding as in Behaviour.
- Undefined: no forwarding paths, and operands come straight from the registered read data. hazard_stall additionally asserts on any nonzero match of id_rs or id_rt against:
  - ex_rd, when ex_valid=1 and ex_reg_write=1;
  - mem_rd, when mem_reg_write=1.
- WB matches never stall in either build, because the register file is write-before-read.

Test Plan:
- Basic latch: id rs_data=0x5, rt_data=0x3, use_imm=0, alu_ctr=3'b101, valid=1 -> next cycle alu_src1=0x5, alu_src2=0x3, alu_ctr=3'b101, ex_valid=1.
- Immediate: use_imm=1, imm=0xFFFFFFFC, rt_data=0x7 -> alu_src2=0xFFFFFFFC, ex_store_data=0x7.
- MEM over WB:
  - stimulus: registered rs=4; mem_rd=4, mem_result=0xAA; wb_rd=4, wb_result=0xBB; both write enables 1;
  - response: alu_src1=0xAA.
  - with mem_reg_write=0 instead: alu_src1=0xBB.
- Register-0 guard: registered rt=0, mem_rd=0, mem_reg_write=1, mem_result=0x1234, rt_data=0 -> alu_src2=0.
- Load-use:
  - stimulus: EX holds mem_read=1, rd=9, valid=1; ID presents rs=9;
  - response: hazard_stall=1; next cycle ex_valid=0 and all ex controls 0.
  - same stimulus with flush_in=1: hazard_stall=0, bubble loaded.
- Stall/reset:
  - stall_in=1 for 3 cycles: outputs held constant.
  - rst_n low mid-stall: all outputs 0 immediately, without waiting for a clock edge.
  - release rst_n: the next edge loads the current ID inputs.
